// File: rtl/sp3a_bus_pkg.sv
// rtl/sp3a_bus_pkg.sv - shared types and widths for the sp3a 32-bit bus target
package sp3a_bus_pkg;

  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int CW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_ACK    = 2'd2,
    ST_RECOV  = 2'd3
  } state_e;

endpackage

// File: rtl/sp3a_ram32be.sv
// rtl/sp3a_ram32be.sv - single-port 2^AW x 32 synchronous RAM, byte write enables, read-first
module sp3a_ram32be
  import sp3a_bus_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic           clk_i,
  input  logic           re_i,
  input  logic [BEW-1:0] we_i,
  input  logic [AW-1:0]  addr_i,
  input  logic [DW-1:0]  wdata_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // No reset on the array or output register so the tools map this onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BEW; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sp3a_ytgt32.sv
// rtl/sp3a_ytgt32.sv - I-Y side 32-bit bus target with wait states over a byte-enabled RAM
// Optional SP3A_YTGT32_WAIT_EN: runtime wait register mapped at the top word of the window.
module sp3a_ytgt32
  import sp3a_bus_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned WAIT = 2
) (
  input  logic           iy_clk,
  input  logic           iy_rst_n,
  input  logic [31:0]    iy_addr,
  input  logic [DW-1:0]  iy_wdata,
  input  logic [BEW-1:0] iy_be,
  input  logic           iy_rd,
  input  logic           iy_req,
  output logic [DW-1:0]  iy_rdata,
  output logic           iy_busy,
  output logic           iy_ack,
  output logic           iy_err
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, wait_val;
  logic [AW-1:0]  idx_q, idx_now, ram_addr;
  logic [DW-1:0]  wdata_q, alt_q, alt_d, ram_rdata;
  logic [BEW-1:0] be_q, ram_we;
  logic           rd_q, hit_q, wreg_q;
  logic           take, hit_now, wreg_now;
  logic           txn_rd, txn_hit, txn_wreg;
  logic           enter_ack, ram_re, wr_commit;
  logic           ack_d, err_d, busy_d, src_q, src_d;
  logic           ack_q, err_q, busy_q;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^iy_addr[1:0];

  assign take    = (state_q == ST_IDLE) && iy_req;
  assign idx_now = iy_addr[AW+1:2];
  assign hit_now = (iy_addr[31:AW+2] == BASE[31:AW+2]);

`ifdef SP3A_YTGT32_WAIT_EN
  logic [CW-1:0] wait_q;
  assign wreg_now = (idx_now == {AW{1'b1}});
  assign wait_val = wait_q;
`else
  assign wreg_now = 1'b0;
  assign wait_val = CW'(WAIT);
`endif

  assign txn_rd   = take ? iy_rd    : rd_q;
  assign txn_hit  = take ? hit_now  : hit_q;
  assign txn_wreg = take ? wreg_now : wreg_q;

  always_ff @(posedge iy_clk) begin
    if (!iy_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      src_q   <= 1'b0;
      alt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      hit_q   <= 1'b0;
      wreg_q  <= 1'b0;
`ifdef SP3A_YTGT32_WAIT_EN
      wait_q  <= CW'(WAIT);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      alt_q   <= alt_d;
      if (take) begin
        idx_q   <= idx_now;
        wdata_q <= iy_wdata;
        be_q    <= iy_be;
        rd_q    <= iy_rd;
        hit_q   <= hit_now;
        wreg_q  <= wreg_now;
      end
`ifdef SP3A_YTGT32_WAIT_EN
      if (wr_commit && wreg_q && be_q[0]) begin
        wait_q <= wdata_q[CW-1:0];
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iy_req) begin
          cnt_d   = wait_val;
          state_d = (wait_val == '0) ? ST_ACK : ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:   state_d = ST_RECOV;
      ST_RECOV: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The RAM read is launched on the edge into ACK so its output register lands exactly in the ack cycle.
  always_comb begin
    enter_ack = (state_d == ST_ACK);
    wr_commit = (state_q == ST_ACK) && !rd_q && hit_q;
    ram_re    = iy_rst_n && enter_ack && txn_rd && txn_hit && !txn_wreg;
    ram_we    = (iy_rst_n && wr_commit && !wreg_q) ? be_q : '0;
    ram_addr  = take ? idx_now : idx_q;
    ack_d     = enter_ack;
    err_d     = enter_ack && !txn_hit;
    busy_d    = (state_d != ST_IDLE);
    src_d     = src_q;
    alt_d     = alt_q;
    if (enter_ack && txn_rd) begin
      src_d = txn_hit && !txn_wreg;
      alt_d = (txn_hit && txn_wreg) ? {{(DW-CW){1'b0}}, wait_val} : '0;
    end
  end

  sp3a_ram32be #(.AW(AW)) u_ram (
    .clk_i   (iy_clk),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign iy_rdata = src_q ? ram_rdata : alt_q;
  assign iy_ack   = ack_q;
  assign iy_err   = err_q;
  assign iy_busy  = busy_q;

endmodule

// File: tb/tb_sp3a_ytgt32.sv
// tb/tb_sp3a_ytgt32.sv - self-checking bench for sp3a_ytgt32 with a cycle-level transaction model
module tb_sp3a_ytgt32;

  localparam int WAIT = 2;

  logic        iy_clk, iy_rst_n;
  logic [31:0] iy_addr, iy_wdata, iy_rdata;
  logic [3:0]  iy_be;
  logic        iy_rd, iy_req, iy_busy, iy_ack, iy_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sp3a_ytgt32 dut (
    .iy_clk   (iy_clk),
    .iy_rst_n (iy_rst_n),
    .iy_addr  (iy_addr),
    .iy_wdata (iy_wdata),
    .iy_be    (iy_be),
    .iy_rd    (iy_rd),
    .iy_req   (iy_req),
    .iy_rdata (iy_rdata),
    .iy_busy  (iy_busy),
    .iy_ack   (iy_ack),
    .iy_err   (iy_err)
  );

  initial begin
    iy_clk = 1'b0;
    forever #5 iy_clk = ~iy_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: each accepted request at cycle T acks at T+1+wait and frees the target at T+3+wait.
  logic [31:0] mem [1024];
  int          mw, idle_from, ack_at, n;
  bit          pend;
  logic        t_rd, t_hit;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        e_busy, e_ack, e_err;
  logic [31:0] e_rdata;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mw = WAIT; idle_from = 0; pend = 0;
    e_busy = 0; e_ack = 0; e_err = 0; e_rdata = 0;
    forever begin
      @(posedge iy_clk);
      n = cyc + 1;
      if (!iy_rst_n) begin
        pend = 0; e_busy = 0; e_ack = 0; e_err = 0; e_rdata = 0;
        idle_from = n; mw = WAIT;
      end else begin
        if (!pend && cyc >= idle_from && iy_req) begin
          t_rd = iy_rd; t_addr = iy_addr; t_wdata = iy_wdata; t_be = iy_be;
          t_hit = (iy_addr[31:12] == 20'h0);
          ack_at = cyc + 1 + mw;
          idle_from = cyc + 3 + mw;
          pend = 1;
        end
        e_busy = (n < idle_from);
        e_ack = 0; e_err = 0;
        if (pend && n == ack_at) begin
          int idx;
          bit is_wreg;
          idx = int'(t_addr[11:2]);
`ifdef SP3A_YTGT32_WAIT_EN
          is_wreg = (idx == 1023);
`else
          is_wreg = 0;
`endif
          pend = 0; e_ack = 1; e_err = !t_hit;
          if (t_rd) begin
            if (!t_hit) e_rdata = 32'h0;
            else if (is_wreg) e_rdata = mw;
            else e_rdata = mem[idx];
          end else if (t_hit) begin
            if (is_wreg) begin
              if (t_be[0]) mw = int'(t_wdata[3:0]);
            end else begin
              for (int b = 0; b < 4; b++)
                if (t_be[b]) mem[idx][8*b +: 8] = t_wdata[8*b +: 8];
            end
          end
        end
      end
      cyc = n;
    end
  end

  initial begin
    forever begin
      @(negedge iy_clk);
      if (cyc >= 1) begin
        chk("ack", {31'h0, iy_ack}, {31'h0, e_ack});
        chk("err", {31'h0, iy_err}, {31'h0, e_err});
        chk("busy", {31'h0, iy_busy}, {31'h0, e_busy});
        chk("rdata", iy_rdata, e_rdata);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge iy_clk);
    while (iy_busy && k < 40) begin
      @(negedge iy_clk);
      k++;
    end
    if (iy_busy) begin
      errors++; checks++;
      $display("FAIL idle_timeout: busy still %b, required 0", iy_busy);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic rd, output int lat, output logic [31:0] rdat, output logic err);
    int  t0;
    bit  got;
    wait_idle();
    iy_addr = a; iy_wdata = d; iy_be = be; iy_rd = rd; iy_req = 1'b1;
    t0 = cyc; got = 0; lat = -1; rdat = 32'hx; err = 1'bx;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge iy_clk);
      if (iy_ack) begin
        got = 1; lat = cyc - t0; rdat = iy_rdata; err = iy_err;
      end
    end
    iy_req = 1'b0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL ack_timeout: no ack for addr %h, required one", a);
    end
  endtask

  int          lat, a1, a2;
  logic [31:0] rd_v;
  logic        er;

  initial begin
    iy_rst_n = 0; iy_req = 0; iy_addr = 0; iy_wdata = 0; iy_be = 0; iy_rd = 0;
    repeat (3) @(negedge iy_clk);
    iy_rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iy_clk);
      chk("idle_busy", {31'h0, iy_busy}, 32'h0);
    end
    chk("idle_ack", {31'h0, iy_ack}, 32'h0);
    chk("idle_err", {31'h0, iy_err}, 32'h0);
    chk("idle_rdata", iy_rdata, 32'h0);

    txn(32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd_v, er);
    chk("wr_latency", lat, 3);
    txn(32'h10, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd_v, 32'hDEADBEEF);
    chk("rd_err", {31'h0, er}, 32'h0);

    txn(32'h10, 32'h11223344, 4'b0101, 0, lat, rd_v, er);
    txn(32'h10, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("partial_data", rd_v, 32'hDE22BE44);

    txn(32'h0, 32'h5A5A1234, 4'hF, 0, lat, rd_v, er);
    txn(32'h00100000, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("miss_rd_err", {31'h0, er}, 32'h1);
    chk("miss_rd_data", rd_v, 32'h0);
    txn(32'h00100000, 32'hFFFFFFFF, 4'hF, 0, lat, rd_v, er);
    chk("miss_wr_err", {31'h0, er}, 32'h1);
    txn(32'h0, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("miss_wr_kept", rd_v, 32'h5A5A1234);

    txn(32'h10, 32'hFFFFFFFF, 4'h0, 0, lat, rd_v, er);
    chk("be0_err", {31'h0, er}, 32'h0);
    txn(32'h10, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("be0_kept", rd_v, 32'hDE22BE44);

    // Request held high across two transactions.
    wait_idle();
    iy_addr = 32'h10; iy_rd = 1; iy_be = 4'hF; iy_req = 1;
    a1 = -1; a2 = -1;
    for (int i = 0; i < 40 && a2 < 0; i++) begin
      @(negedge iy_clk);
      if (iy_ack) begin
        if (a1 < 0) a1 = cyc; else a2 = cyc;
      end
    end
    iy_req = 0;
    chk("held_spacing", a2 - a1, WAIT + 3);
    chk("held_data", iy_rdata, 32'hDE22BE44);

    // Reset while a write is waiting.
    wait_idle();
    iy_addr = 32'h10; iy_wdata = 32'hCAFEF00D; iy_be = 4'hF; iy_rd = 0; iy_req = 1;
    @(negedge iy_clk);
    chk("rst_busy_before", {31'h0, iy_busy}, 32'h1);
    iy_rst_n = 0; iy_req = 0;
    repeat (2) @(negedge iy_clk);
    iy_rst_n = 1;
    chk("rst_ack", {31'h0, iy_ack}, 32'h0);
    chk("rst_busy", {31'h0, iy_busy}, 32'h0);
    chk("rst_rdata", iy_rdata, 32'h0);
    txn(32'h10, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("rst_word_kept", rd_v, 32'hDE22BE44);

`ifdef SP3A_YTGT32_WAIT_EN
    txn(32'hFFC, 32'h0, 4'h1, 0, lat, rd_v, er);
    txn(32'hFFC, 32'h0, 4'hF, 1, lat, rd_v, er);
    chk("wreg_latency", lat, 1);
    chk("wreg_data", rd_v, 32'h0);
`endif

    repeat (4) @(negedge iy_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
